// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI-style round-robin bus arbiter.
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_MASTERS  = 4;
  localparam int DEF_GNT_TIMEOUT  = 16;
  localparam int DEF_BUSY_TIMEOUT = 256;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Timeout counter width: wide enough for the larger timeout, never zero.
  function automatic int cnt_width(input int gnt_to, input int busy_to);
    int w;
    w = clog2((gnt_to > busy_to) ? gnt_to : busy_to);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pci_arb_rr_pick.sv
// Round-robin winner selection: rotate requests so the slot after ptr is bit 0,
// pick the lowest set bit, then map the offset back to a master index.
module pci_arb_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win
);

  logic [IDX_W:0] start;
  logic [IDX_W:0] off;
  logic [IDX_W:0] sum;
  logic [N-1:0]   rot;

  // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    any   = |req;
    start = (ptr == IDX_W'(N - 1)) ? '0 : ({1'b0, ptr} + 1'b1);
    rot   = N'({req, req} >> start);
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDX_W + 1)'(i);
    end
    sum = start + off;
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    win = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin arbiter with unused-grant revoke and hung-transaction abort.
// Define ARB_PARK_EN to park the grant on the last owner while the bus is idle.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter  int NUM_MASTERS  = DEF_NUM_MASTERS,
  parameter  int GNT_TIMEOUT  = DEF_GNT_TIMEOUT,
  parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IDX_W        = clog2(NUM_MASTERS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] REQ_B,
  output logic [NUM_MASTERS-1:0] GNT_B,
  input  logic                   FRAME_B,
  input  logic                   IRDY_B,
  input  logic                   TRDY_B,
  output logic [IDX_W-1:0]       OWNER,
  output logic                   BUS_BUSY,
  output logic                   TIMEOUT,
  output logic                   ABORT
);

  localparam int CNT_W = cnt_width(GNT_TIMEOUT, BUSY_TIMEOUT);

  arb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] gnt_b_q, gnt_b_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic                   bus_busy_q, bus_busy_d;
  logic                   timeout_q, timeout_d;
  logic                   abort_q, abort_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   req_any;
  logic [IDX_W-1:0]       win;
  logic                   frame_seen;
  logic                   xfer_done;

  // Floating or unknown bus lines must read as deasserted.
  assign frame_seen = (FRAME_B === 1'b0);
  assign xfer_done  = (IRDY_B === 1'b0) && (TRDY_B === 1'b0);
  assign req        = ~REQ_B;

  pci_arb_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .any (req_any),
    .win (win)
  );

`ifdef ARB_PARK_EN
  logic parked;
  assign parked = ~&gnt_b_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_b_d    = gnt_b_q;
    owner_d    = owner_q;
    bus_busy_d = bus_busy_q;
    timeout_d  = 1'b0;
    abort_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef ARB_PARK_EN
        if (parked && frame_seen) begin
          gnt_b_d    = '1;
          owner_d    = rr_ptr_q;
          bus_busy_d = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (parked && req[rr_ptr_q]) begin
          owner_d = rr_ptr_q;
          cnt_d   = '0;
          state_d = GRANT;
        end else if (parked && req_any) begin
          // Another master wants the bus: drop the park and arbitrate after turnaround.
          gnt_b_d = '1;
          state_d = TURN;
        end else if (req_any) begin
          gnt_b_d  = ~(NUM_MASTERS'(1) << win);
          owner_d  = win;
          rr_ptr_d = win;
          cnt_d    = '0;
          state_d  = GRANT;
        end else begin
          gnt_b_d = ~(NUM_MASTERS'(1) << rr_ptr_q);
        end
`else
        if (req_any) begin
          gnt_b_d  = ~(NUM_MASTERS'(1) << win);
          owner_d  = win;
          rr_ptr_d = win;
          cnt_d    = '0;
          state_d  = GRANT;
        end
`endif
      end
      GRANT: begin
        if (frame_seen) begin
          gnt_b_d    = '1;
          bus_busy_d = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (cnt_q == CNT_W'(GNT_TIMEOUT - 1)) begin
          gnt_b_d   = '1;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (xfer_done) begin
          bus_busy_d = 1'b0;
          cnt_d      = '0;
          state_d    = TURN;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          bus_busy_d = 1'b0;
          abort_d    = 1'b1;
          cnt_d      = '0;
          state_d    = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        gnt_b_d = '1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments and the async reset clears every one of them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= IDX_W'(NUM_MASTERS - 1);
      gnt_b_q    <= '1;
      owner_q    <= '0;
      bus_busy_q <= 1'b0;
      timeout_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_b_q    <= gnt_b_d;
      owner_q    <= owner_d;
      bus_busy_q <= bus_busy_d;
      timeout_q  <= timeout_d;
      abort_q    <= abort_d;
    end
  end

  assign GNT_B    = gnt_b_q;
  assign OWNER    = owner_q;
  assign BUS_BUSY = bus_busy_q;
  assign TIMEOUT  = timeout_q;
  assign ABORT    = abort_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (default build, parking disabled).
module tb_pci_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] REQ_B = 4'b1111;
  logic [3:0] GNT_B;
  logic       FRAME_B = 1'b1;
  logic       IRDY_B = 1'b1;
  logic       TRDY_B = 1'b1;
  logic [1:0] OWNER;
  logic       BUS_BUSY, TIMEOUT, ABORT;

  int n_checks = 0;
  int n_pass   = 0;

  pci_bus_arbiter #(
    .NUM_MASTERS  (4),
    .GNT_TIMEOUT  (16),
    .BUSY_TIMEOUT (256)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ_B    (REQ_B),
    .GNT_B    (GNT_B),
    .FRAME_B  (FRAME_B),
    .IRDY_B   (IRDY_B),
    .TRDY_B   (TRDY_B),
    .OWNER    (OWNER),
    .BUS_BUSY (BUS_BUSY),
    .TIMEOUT  (TIMEOUT),
    .ABORT    (ABORT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] req_b;
    logic       frame_b;
    logic       irdy_b;
    logic       trdy_b;
    logic [3:0] gnt_b;
    logic [1:0] owner;
    logic       busy;
    logic       to;
    logic       ab;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [3:0] req_b, input logic frame_b, input logic irdy_b,
                              input logic trdy_b, input logic [3:0] gnt_b, input logic [1:0] owner,
                              input logic busy);
    vec_t v;
    v.req_b = req_b; v.frame_b = frame_b; v.irdy_b = irdy_b; v.trdy_b = trdy_b;
    v.gnt_b = gnt_b; v.owner = owner; v.busy = busy; v.to = 1'b0; v.ab = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input string name, input logic [3:0] gnt, input logic [1:0] own,
                           input logic busy, input logic to, input logic ab);
    check({name, ".gnt_b"},    32'(GNT_B),    32'(gnt));
    check({name, ".owner"},    32'(OWNER),    32'(own));
    check({name, ".bus_busy"}, 32'(BUS_BUSY), 32'(busy));
    check({name, ".timeout"},  32'(TIMEOUT),  32'(to));
    check({name, ".abort"},    32'(ABORT),    32'(ab));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] req_b, input logic frame_b, input logic irdy_b,
                       input logic trdy_b);
    REQ_B = req_b; FRAME_B = frame_b; IRDY_B = irdy_b; TRDY_B = trdy_b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and round-robin sequence; each row is inputs applied before one edge
    // and the outputs expected just after it.
    vecs[0]  = mk(4'b1110, 1, 1, 1, 4'b1110, 2'd0, 0); // grant master 0
    vecs[1]  = mk(4'b1111, 0, 1, 1, 4'b1111, 2'd0, 1); // FRAME seen
    vecs[2]  = mk(4'b1111, 0, 1, 1, 4'b1111, 2'd0, 1); // still busy
    vecs[3]  = mk(4'b1111, 1, 0, 0, 4'b1111, 2'd0, 0); // completion -> TURN
    vecs[4]  = mk(4'b0000, 1, 1, 1, 4'b1111, 2'd0, 0); // TURN -> IDLE, no grant yet
    vecs[5]  = mk(4'b0000, 1, 1, 1, 4'b1101, 2'd1, 0);
    vecs[6]  = mk(4'b0000, 0, 1, 1, 4'b1111, 2'd1, 1);
    vecs[7]  = mk(4'b0000, 1, 0, 0, 4'b1111, 2'd1, 0);
    vecs[8]  = mk(4'b0000, 1, 1, 1, 4'b1111, 2'd1, 0);
    vecs[9]  = mk(4'b0000, 1, 1, 1, 4'b1011, 2'd2, 0);
    vecs[10] = mk(4'b0000, 0, 1, 1, 4'b1111, 2'd2, 1);
    vecs[11] = mk(4'b0000, 1, 0, 0, 4'b1111, 2'd2, 0);
    vecs[12] = mk(4'b0000, 1, 1, 1, 4'b1111, 2'd2, 0);
    vecs[13] = mk(4'b0000, 1, 1, 1, 4'b0111, 2'd3, 0);
    vecs[14] = mk(4'b0000, 0, 1, 1, 4'b1111, 2'd3, 1);
    vecs[15] = mk(4'b0000, 1, 0, 0, 4'b1111, 2'd3, 0);
    vecs[16] = mk(4'b0000, 1, 1, 1, 4'b1111, 2'd3, 0);
    vecs[17] = mk(4'b0000, 1, 1, 1, 4'b1110, 2'd0, 0); // wraps back to master 0
    vecs[18] = mk(4'b1111, 0, 1, 1, 4'b1111, 2'd0, 1);
    vecs[19] = mk(4'b1111, 1, 0, 0, 4'b1111, 2'd0, 0);
    vecs[20] = mk(4'b1111, 1, 1, 1, 4'b1111, 2'd0, 0); // back in IDLE, rr_ptr = 0

    #2 RST = 1'b1;
    #1 check_all("reset_async", 4'b1111, 2'd0, 0, 0, 0);
    step();
    step();
    check_all("reset_held", 4'b1111, 2'd0, 0, 0, 0);
    RST = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].req_b, vecs[i].frame_b, vecs[i].irdy_b, vecs[i].trdy_b);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].gnt_b, vecs[i].owner, vecs[i].busy,
                vecs[i].to, vecs[i].ab);
    end

    // Unused grant: masters 2 and 3 request, master 2 wins; it then drops REQ
    // (ignored), never drives FRAME, and the grant is revoked after 16 edges.
    drive(4'b0011, 1, 1, 1);
    step();
    check_all("gto_grant", 4'b1011, 2'd2, 0, 0, 0);
    drive(4'b0111, 1, 1, 1);
    for (int i = 1; i < 16; i++) step();
    check_all("gto_edge15", 4'b1011, 2'd2, 0, 0, 0);
    step();
    check_all("gto_revoke", 4'b1111, 2'd2, 0, 1, 0);
    step();
    check_all("gto_pulse_end", 4'b1111, 2'd2, 0, 0, 0);
    step();
    check_all("gto_next_m3", 4'b0111, 2'd3, 0, 0, 0);

    // Hung transaction: FRAME low, TRDY never low -> ABORT after 256 busy edges.
    drive(4'b1111, 0, 1, 1);
    step();
    check_all("bto_busy", 4'b1111, 2'd3, 1, 0, 0);
    for (int i = 1; i < 256; i++) step();
    check_all("bto_edge255", 4'b1111, 2'd3, 1, 0, 0);
    step();
    check_all("bto_abort", 4'b1111, 2'd3, 0, 0, 1);
    drive(4'b1111, 1, 1, 1);
    step();
    check_all("bto_pulse_end", 4'b1111, 2'd3, 0, 0, 0);
    step();

    // FRAME arrives on the same edge the grant timeout expires: FRAME wins.
    drive(4'b1110, 1, 1, 1); // rr_ptr = 3, master 0 wins
    step();
    check_all("race_grant", 4'b1110, 2'd0, 0, 0, 0);
    for (int i = 1; i < 16; i++) step();
    drive(4'b1111, 0, 1, 1);
    step();
    check_all("race_frame_wins", 4'b1111, 2'd0, 1, 0, 0);

    // Completion on the same edge the busy timeout expires: no ABORT.
    for (int i = 1; i < 256; i++) step();
    drive(4'b1111, 1, 0, 0);
    step();
    check_all("race_done_wins", 4'b1111, 2'd0, 0, 0, 0);
    drive(4'b1111, 1, 1, 1);
    step();
    step();

    // Async reset while a grant is held, then while busy.
    drive(4'b1101, 1, 1, 1); // rr_ptr = 0, master 1 wins
    step();
    check_all("rst_pre_grant", 4'b1101, 2'd1, 0, 0, 0);
    #3 RST = 1'b1;
    #1 check_all("rst_in_grant", 4'b1111, 2'd0, 0, 0, 0);
    drive(4'b1011, 1, 1, 1);
    step();
    RST = 1'b0;
    step();
    check_all("rst_ptr_restart", 4'b1011, 2'd2, 0, 0, 0);
    drive(4'b1111, 0, 1, 1);
    step();
    check_all("rst_pre_busy", 4'b1111, 2'd2, 1, 0, 0);
    #3 RST = 1'b1;
    #1 check_all("rst_in_busy", 4'b1111, 2'd0, 0, 0, 0);
    drive(4'b0000, 1, 1, 1);
    step();
    RST = 1'b0;
    step();
    check_all("rst_after_busy", 4'b1110, 2'd0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
